sccb_config_ctrl: RTL and testbench



---
 rtl/sccb_config_ctrl.sv | 132 +++++++++++++
 tb/tb_sccb_config_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_ctrl.sv
// sccb_config_ctrl: walks a camera register table from a synchronous ROM and issues each entry as an SCCB 3-phase write
module sccb_config_ctrl #(
    parameter int         CLK_DIV      = 60,
    parameter logic [7:0] CAM_ID       = 8'h42,
    parameter int         BOOT_CYCLES  = 24000,
    parameter int         DELAY_CYCLES = 240000,
    parameter int         GAP_CYCLES   = 240,
    parameter int         MAX_ENTRIES  = 256
) (
    input  logic        CLOCK_24,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        SIOC,
    output logic        siod_out,
    output logic        siod_oe,
    output logic        busy,
    output logic        done,
    output logic [7:0]  write_count
);
    typedef enum logic [2:0] {BOOT, FETCH, START, SHIFT, STOP, GAP, DELAY, DONE} state_t;
    localparam logic [31:0] QT = 32'(CLK_DIV - 1);
    localparam logic [31:0] BT = 32'(BOOT_CYCLES - 1);
    localparam logic [31:0] DT = 32'(DELAY_CYCLES - 1);
    localparam logic [31:0] GT = 32'(GAP_CYCLES - 1);
    localparam logic [7:0]  LAST = 8'(MAX_ENTRIES - 1);
    localparam logic [2:0]  IDLE = 3'b110;
    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  q;
    logic [4:0]  bidx;
    logic [26:0] sh;
    logic        tick;
    assign tick = cnt == QT;
    // Bus levels {SIOC, siod_out, siod_oe} for a given state and quarter; outputs are loaded with the next quarter's value
    function automatic logic [2:0] bus(input state_t s, input logic [1:0] qq, input logic b, input logic ack);
        return s == START ? (qq == 2'd0 ? 3'b111 : qq == 2'd1 ? 3'b101 : 3'b001) :
               s == SHIFT ? {qq == 2'd1 || qq == 2'd2, b, !ack} :
               s == STOP  ? (qq == 2'd0 ? 3'b001 : qq == 2'd1 ? 3'b101 : 3'b111) : IDLE;
    endfunction
    function automatic logic is_ack(input logic [4:0] n);
        return n == 5'd8 || n == 5'd17 || n == 5'd26;
    endfunction
    always_ff @(posedge CLOCK_24) begin
        if (rst) begin
            state <= BOOT;
            cnt <= '0;
            q <= '0;
            bidx <= '0;
            sh <= '0;
            rom_addr <= '0;
            write_count <= '0;
            {SIOC, siod_out, siod_oe} <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    busy <= 1'b1;
                    cnt <= cnt == BT ? '0 : cnt + 1;
                    if (cnt == BT) state <= FETCH;
                end
                FETCH: begin
                    cnt <= cnt == 32'd2 ? '0 : cnt + 1;
                    if (cnt == 32'd2) begin
                        if (rom_data == 16'hFFFF) begin
                            state <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else if (rom_data == 16'hFFF0) begin
                            state <= DELAY;
                        end else begin
                            state <= START;
                            q <= '0;
                            bidx <= '0;
                            sh <= {CAM_ID, 1'b0, rom_data[15:8], 1'b0, rom_data[7:0], 1'b0};
                            {SIOC, siod_out, siod_oe} <= bus(START, 2'd0, 1'b0, 1'b0);
                        end
                    end
                end
                START, SHIFT, STOP: begin
                    cnt <= tick ? '0 : cnt + 1;
                    if (tick) begin
                        q <= q + 2'd1;
                        if (q != 2'd3) begin
                            {SIOC, siod_out, siod_oe} <= bus(state, q + 2'd1, sh[26], is_ack(bidx));
                        end else if (state == START) begin
                            state <= SHIFT;
                            {SIOC, siod_out, siod_oe} <= bus(SHIFT, 2'd0, sh[26], 1'b0);
                        end else if (state == SHIFT && bidx != 5'd26) begin
                            bidx <= bidx + 5'd1;
                            sh <= {sh[25:0], 1'b0};
                            {SIOC, siod_out, siod_oe} <= bus(SHIFT, 2'd0, sh[25], is_ack(bidx + 5'd1));
                        end else if (state == SHIFT) begin
                            state <= STOP;
                            {SIOC, siod_out, siod_oe} <= bus(STOP, 2'd0, 1'b0, 1'b0);
                        end else begin
                            state <= GAP;
                            write_count <= write_count + {7'd0, write_count != 8'hFF};
                            {SIOC, siod_out, siod_oe} <= IDLE;
                        end
                    end
                end
                GAP, DELAY: begin
                    cnt <= cnt == (state == GAP ? GT : DT) ? '0 : cnt + 1;
                    if (cnt == (state == GAP ? GT : DT)) begin
                        if (rom_addr == LAST) begin
                            state <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            state <= FETCH;
                            rom_addr <= rom_addr + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= FETCH;
                        cnt <= '0;
                        rom_addr <= '0;
                        write_count <= '0;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_config_ctrl.sv
// tb_sccb_config_ctrl: table-driven check of SCCB frames decoded off the bus, plus reset/restart/end-of-table sequences
module tb_sccb_config_ctrl;
    localparam int NW = 5;
    typedef struct {
        logic [15:0] word;
        logic [7:0]  sub;
        logic [7:0]  val;
        bit          wr;
    } vec_t;
    logic clk = 0, rst = 1, start = 0, rst4 = 1;
    logic [7:0] rom_addr, rom_addr4, write_count, write_count4;
    logic [15:0] rom_data = 0, rom_data4 = 0;
    logic SIOC, siod_out, siod_oe, busy, done;
    logic SIOC4, siod_out4, siod_oe4, busy4, done4;
    logic [15:0] rom [256];
    logic [15:0] rom4 [256];
    vec_t vecs [6];
    int nvec = 0, nmis = 0, cyc = 0;
    logic p_sioc = 1, p_w = 1, p_oe = 0, w;
    bit in_frame = 0, ackok;
    int nb = 0, fs = 0, hi_toggles = 0, sioc_edges = 0;
    logic [26:0] cur;
    logic [26:0] fbits[$];
    int flen[$], fstart[$], fend[$];
    bit fack[$];

    sccb_config_ctrl #(.CLK_DIV(4), .BOOT_CYCLES(10), .DELAY_CYCLES(50), .GAP_CYCLES(8)) u_dut (
        .CLOCK_24(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .SIOC(SIOC), .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy), .done(done), .write_count(write_count));
    sccb_config_ctrl #(.CLK_DIV(4), .BOOT_CYCLES(10), .DELAY_CYCLES(50), .GAP_CYCLES(8), .MAX_ENTRIES(4)) u_dut4 (
        .CLOCK_24(clk), .rst(rst4), .start(1'b0), .rom_addr(rom_addr4), .rom_data(rom_data4),
        .SIOC(SIOC4), .siod_out(siod_out4), .siod_oe(siod_oe4), .busy(busy4), .done(done4), .write_count(write_count4));

    always #5 clk = ~clk;
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        rom_data4 <= rom4[rom_addr4];
        cyc <= cyc + 1;
    end

    // Bus monitor: frames delimited by SIOD release/drive while SIOC is high; bits sampled on SIOC rise
    initial forever begin
        @(negedge clk);
        w = siod_oe ? siod_out : 1'b1;
        if (rst) in_frame = 0;
        else begin
            if (SIOC && p_sioc && w != p_w) hi_toggles++;
            if (SIOC != p_sioc) sioc_edges++;
            if (siod_oe && !p_oe && SIOC && p_sioc) begin
                in_frame = 1; nb = 0; fs = cyc; cur = '0; ackok = 1;
            end else if (in_frame && SIOC && !p_sioc && nb < 27) begin
                cur[26-nb] = w;
                if (siod_oe == (nb == 8 || nb == 17 || nb == 26)) ackok = 0;
                nb++;
            end else if (in_frame && SIOC && p_oe && !siod_oe) begin
                fbits.push_back(cur); flen.push_back(cyc - fs); fstart.push_back(fs);
                fend.push_back(cyc); fack.push_back(ackok && nb == 27); in_frame = 0;
            end
        end
        p_sioc = SIOC; p_w = w; p_oe = siod_oe;
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic clear();
        fbits.delete(); flen.delete(); fstart.delete(); fend.delete(); fack.delete();
        hi_toggles = 0; sioc_edges = 0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin @(posedge clk); #1; n++; end
        chk("done_wait", done, 1);
    endtask

    task automatic wait_frame(input int nfr, input int nbit);
        int n = 0;
        while (!(in_frame && fbits.size() == nfr && nb >= nbit) && n < 5000) begin @(posedge clk); #1; n++; end
        chk("frame_wait", n < 5000, 1);
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic check_frames();
        int k = 0;
        bit after_delay = 0;
        logic [26:0] b;
        chk("frame_count", fbits.size(), NW);
        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].wr) after_delay = 1;
            else begin
                if (k < fbits.size()) begin
                    b = fbits[k];
                    chk($sformatf("id[%0d]", k), b[26:19], 8'h42);
                    chk($sformatf("sub[%0d]", k), b[17:10], vecs[i].sub);
                    chk($sformatf("val[%0d]", k), b[8:1], vecs[i].val);
                    chk($sformatf("len[%0d]", k), flen[k], 464);
                    chk($sformatf("ack_release[%0d]", k), fack[k], 1);
                    if (after_delay && k > 0) chk($sformatf("delay_gap[%0d]", k), fstart[k] - fend[k-1] >= 50, 1);
                end
                after_delay = 0;
                k++;
            end
        end
        chk("sioc_high_toggles", hi_toggles, 2 * NW);
    endtask

    initial begin
        int n;
        vecs = '{'{16'h1280, 8'h12, 8'h80, 1'b1}, '{16'hFFF0, 8'h00, 8'h00, 1'b0},
                 '{16'h1204, 8'h12, 8'h04, 1'b1}, '{16'h3AFF, 8'h3A, 8'hFF, 1'b1},
                 '{16'h0000, 8'h00, 8'h00, 1'b1}, '{16'hFF7E, 8'hFF, 8'h7E, 1'b1}};
        for (int i = 0; i < 256; i++) begin
            rom[i] = i < 6 ? vecs[i].word : 16'hFFFF;
            rom4[i] = i < 4 ? 16'(16'h0101 + i) : 16'h0105;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("rst_SIOC", SIOC, 1); chk("rst_siod_out", siod_out, 1); chk("rst_siod_oe", siod_oe, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rom_addr", rom_addr, 0);
        chk("rst_write_count", write_count, 0);
        rst = 0; rst4 = 0;
        @(posedge clk); #1;
        chk("boot_busy", busy, 1);
        wait_done(20000);
        check_frames();
        chk("run1_write_count", write_count, NW); chk("run1_busy", busy, 0);

        clear();
        pulse_start();
        chk("restart_done", done, 0); chk("restart_busy", busy, 1);
        chk("restart_write_count", write_count, 0); chk("restart_rom_addr", rom_addr, 0);
        wait_done(20000);
        check_frames();
        chk("run2_write_count", write_count, NW);

        clear();
        pulse_start();
        wait_frame(0, 12);
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_SIOC", SIOC, 1); chk("midrst_siod_oe", siod_oe, 0);
        chk("midrst_busy", busy, 0); chk("midrst_rom_addr", rom_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        clear();
        rst = 0;
        wait_frame(1, 0);
        chk("busy_start_addr_before", rom_addr, 2);
        pulse_start();
        chk("busy_start_addr_after", rom_addr, 2); chk("busy_start_busy", busy, 1);
        wait_done(20000);
        check_frames();
        chk("run3_write_count", write_count, NW);

        rom[0] = 16'hFFFF;
        rst = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("rst_wins_busy", busy, 0); chk("rst_wins_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        clear();
        rst = 0;
        n = 0;
        while (!done && n < 100) begin @(posedge clk); n++; #1; end
        chk("empty_done_latency", n, 13);
        chk("empty_sioc_edges", sioc_edges, 0); chk("empty_write_count", write_count, 0);
        chk("empty_frames", fbits.size(), 0);
        pulse_start();
        n = 0;
        while (!done && n < 100) begin @(posedge clk); n++; #1; end
        chk("empty_restart_latency", n, 3);

        chk("max_write_count", write_count4, 4); chk("max_done", done4, 1);
        chk("max_rom_addr", rom_addr4, 3); chk("max_busy", busy4, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
